cpu_step_display: RTL and testbench

Board-level front end for the multi-cycle MIPS CPU.
- Debounces the manual step push-button and drives the CPU clock (CLK of the CPU top) one step per press.
- Consumes the CPU's debug outputs and scans four active-low seven-segment digits.
- A 2-bit selector chooses which pair of 8-bit values is shown.

---
 rtl/cpu_step_display_pkg.sv | 15 +
 rtl/cpu_step_display_hex_to_seg7.sv | 9 +
 rtl/cpu_step_display.sv | 76 +++++++
 tb/tb_cpu_step_display.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/cpu_step_display_pkg.sv
// cpu_step_display_pkg: shared display encodings and seven-segment code table
package cpu_step_display_pkg;
  typedef enum logic [1:0] {
    SEL_PC  = 2'b00,
    SEL_RS  = 2'b01,
    SEL_RT  = 2'b10,
    SEL_ALU = 2'b11
  } displaySel;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
endpackage

// File: rtl/cpu_step_display_hex_to_seg7.sv
// hex_to_seg7: active-low seven-segment code for one hex nibble, dp off
module hex_to_seg7
  import cpu_step_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] segCode
);
  assign segCode = SEG_TABLE[hex];
endmodule

// File: rtl/cpu_step_display.sv
// cpu_step_display: debounced manual CPU step clock plus four-digit multiplexed debug display
module cpu_step_display
  import cpu_step_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCAN_DIV        = 100000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        step_btn,
  input  logic [1:0]  sel,
  input  logic [31:0] pc,
  input  logic [31:0] next_pc,
  input  logic [4:0]  rs,
  input  logic [31:0] read_data1,
  input  logic [4:0]  rt,
  input  logic [31:0] read_data2,
  input  logic [31:0] alu_result,
  input  logic [31:0] data_out,
  output logic        step_clk,
  output logic        step_pulse,
  output logic [3:0]  anode,
  output logic [7:0]  seg
);
  localparam int DebW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ScanW = $clog2(SCAN_DIV + 1);
  localparam logic [DebW-1:0] DebLast = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
  logic syncA, syncB, differ, accept, tick;
  logic [DebW-1:0] debCnt;
  logic [ScanW-1:0] scanCnt;
  logic [1:0] digitIdx, nextIdx;
  logic [7:0] hiByte, loByte, segCode;
  logic [3:0] nibble;
  assign differ = syncB != step_clk;
  assign accept = differ && debCnt == DebLast;
  assign tick = scanCnt == ScanLast;
  assign nextIdx = digitIdx + 2'd1;
  assign hiByte = sel == SEL_PC ? pc[7:0] : sel == SEL_RS ? {3'b0, rs} : sel == SEL_RT ? {3'b0, rt} : alu_result[7:0];
  assign loByte = sel == SEL_PC ? next_pc[7:0] : sel == SEL_RS ? read_data1[7:0] : sel == SEL_RT ? read_data2[7:0] : data_out[7:0];
  assign nibble = nextIdx == 2'd0 ? loByte[3:0] : nextIdx == 2'd1 ? loByte[7:4] : nextIdx == 2'd2 ? hiByte[3:0] : hiByte[7:4];
  hex_to_seg7 decoder (.hex(nibble), .segCode(segCode));
  // two-flop synchroniser for the asynchronous push-button
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      syncA <= 1'b0;
      syncB <= 1'b0;
    end else begin
      syncA <= step_btn;
      syncB <= syncA;
    end
  // accept a new button level only after it has differed for DEBOUNCE_CYCLES samples; strobe on press only
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      debCnt <= '0;
      step_clk <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      debCnt <= differ && !accept ? debCnt + DebW'(1) : '0;
      step_clk <= accept ? syncB : step_clk;
      step_pulse <= accept && syncB;
    end
  // scan divider; anode and seg load together for the next digit on each tick
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      scanCnt <= '0;
      digitIdx <= 2'd0;
      anode <= ANODE_OFF;
      seg <= SEG_BLANK;
    end else begin
      scanCnt <= tick ? '0 : scanCnt + ScanW'(1);
      digitIdx <= tick ? nextIdx : digitIdx;
      anode <= tick ? ~(4'b0001 << nextIdx) : anode;
      seg <= tick ? segCode : seg;
    end
endmodule

// File: tb/tb_cpu_step_display.sv
// tb_cpu_step_display: table-driven display scoreboard plus hand-written debounce sequences
module tb_cpu_step_display;
  localparam int DEB = 4;
  localparam int SD = 2;
  localparam logic [7:0] REF_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  logic CLK = 1'b0, Reset = 1'b1, step_btn = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [31:0] pc = '0, next_pc = '0, read_data1 = '0, read_data2 = '0, alu_result = '0, data_out = '0;
  logic [4:0] rs = '0, rt = '0;
  logic step_clk, step_pulse;
  logic [3:0] anode;
  logic [7:0] seg;
  int nVec = 0, nErr = 0;
  int pulses = 0, rises = 0;
  logic monOn = 1'b0, prevClk = 1'b0;
  logic [1:0] idx;
  logic [3:0] lastAnode;
  logic [7:0] lastSeg;
  typedef struct {
    logic [1:0] sel;
    logic [31:0] pc, npc;
    logic [4:0] rs;
    logic [31:0] rd1;
    logic [4:0] rt;
    logic [31:0] rd2, alu, dout;
    logic [7:0] hi, lo;
    int ticks;
  } vec_t;
  typedef struct {
    logic [3:0] anode;
    logic [7:0] seg;
  } disp_t;
  disp_t expQ[$];
  vec_t vecs[6];
  always #5 CLK = ~CLK;
  cpu_step_display #(.DEBOUNCE_CYCLES(DEB), .SCAN_DIV(SD)) dut (
    .CLK(CLK), .Reset(Reset), .step_btn(step_btn), .sel(sel),
    .pc(pc), .next_pc(next_pc), .rs(rs), .read_data1(read_data1),
    .rt(rt), .read_data2(read_data2), .alu_result(alu_result), .data_out(data_out),
    .step_clk(step_clk), .step_pulse(step_pulse), .anode(anode), .seg(seg)
  );
  always @(negedge CLK) begin
    prevClk <= step_clk;
    if (monOn) begin
      pulses <= pulses + (step_pulse ? 1 : 0);
      rises <= rises + ((step_clk && !prevClk) ? 1 : 0);
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic doReset();
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
  endtask
  task automatic scanStep(input logic [7:0] hi, input logic [7:0] lo);
    disp_t e;
    logic [3:0] nib;
    @(posedge CLK);
    @(negedge CLK);
    check("hold_anode", 32'(anode), 32'(lastAnode));
    check("hold_seg", 32'(seg), 32'(lastSeg));
    idx = idx + 2'd1;
    nib = idx == 2'd0 ? lo[3:0] : idx == 2'd1 ? lo[7:4] : idx == 2'd2 ? hi[3:0] : hi[7:4];
    expQ.push_back('{~(4'b0001 << idx), REF_SEG[nib]});
    @(posedge CLK);
    @(negedge CLK);
    e = expQ.pop_front();
    check("tick_anode", 32'(anode), 32'(e.anode));
    check("tick_seg", 32'(seg), 32'(e.seg));
    lastAnode = e.anode;
    lastSeg = e.seg;
  endtask
  task automatic btnRun(input logic level, input int n, input int edgeAt);
    step_btn = level;
    for (int c = 1; c <= n; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      check("step_clk", 32'(step_clk), 32'(level ? (c >= edgeAt) : (c < edgeAt)));
      check("step_pulse", 32'(step_pulse), 32'(level && c == edgeAt));
    end
  endtask
  initial begin
    vecs[0] = '{2'b00, 32'h0000_0014, 32'h0000_0018, 5'd3, 32'h77, 5'd9, 32'h66, 32'h55, 32'h44, 8'h14, 8'h18, 4};
    vecs[1] = '{2'b11, 32'h12, 32'h34, 5'd7, 32'h21, 5'd2, 32'h43, 32'h0000_00AB, 32'hFFFF_FFCD, 8'hAB, 8'hCD, 2};
    vecs[2] = '{2'b01, 32'h12, 32'h34, 5'd31, 32'h0000_000F, 5'd2, 32'h43, 32'hAB, 32'hCD, 8'h1F, 8'h0F, 4};
    vecs[3] = '{2'b10, 32'h99, 32'h88, 5'd4, 32'hBB, 5'd5, 32'h1234_5678, 32'hC3, 32'h3C, 8'h05, 8'h78, 4};
    vecs[4] = '{2'b00, 32'hDEAD_BEEF, 32'h0, 5'd1, 32'h2, 5'd3, 32'h4, 32'h6, 32'h7, 8'hEF, 8'h00, 4};
    vecs[5] = '{2'b11, 32'h1, 32'h2, 5'd10, 32'hA6, 5'd20, 32'hB2, 32'h0000_129A, 32'h8765_4363, 8'h9A, 8'h63, 4};
    doReset();
    check("rst_anode", 32'(anode), 32'hF);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_step_clk", 32'(step_clk), 32'h0);
    check("rst_step_pulse", 32'(step_pulse), 32'h0);
    idx = 2'd0;
    lastAnode = 4'hF;
    lastSeg = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      sel = vecs[i].sel;
      pc = vecs[i].pc;
      next_pc = vecs[i].npc;
      rs = vecs[i].rs;
      read_data1 = vecs[i].rd1;
      rt = vecs[i].rt;
      read_data2 = vecs[i].rd2;
      alu_result = vecs[i].alu;
      data_out = vecs[i].dout;
      for (int t = 0; t < vecs[i].ticks; t++) scanStep(vecs[i].hi, vecs[i].lo);
    end
    @(negedge CLK);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_anode", 32'(anode), 32'hF);
    check("async_rst_seg", 32'(seg), 32'hFF);
    @(negedge CLK);
    Reset = 1'b0;
    btnRun(1'b1, 8, 6);
    btnRun(1'b0, 8, 6);
    for (int c = 0; c < 16; c++) begin
      step_btn = c < 8 && (c / 2) % 2 == 0;
      @(posedge CLK);
      @(negedge CLK);
      check("bounce_clk", 32'(step_clk), 32'h0);
      check("bounce_pulse", 32'(step_pulse), 32'h0);
    end
    btnRun(1'b1, 8, 6);
    #2 Reset = 1'b1;
    #1;
    check("midpress_rst_clk", 32'(step_clk), 32'h0);
    check("midpress_rst_pulse", 32'(step_pulse), 32'h0);
    check("midpress_rst_anode", 32'(anode), 32'hF);
    check("midpress_rst_seg", 32'(seg), 32'hFF);
    @(negedge CLK);
    Reset = 1'b0;
    btnRun(1'b1, 8, 6);
    btnRun(1'b0, 8, 6);
    monOn = 1'b1;
    for (int p = 0; p < 10; p++) begin
      step_btn = 1'b1;
      repeat (8) @(negedge CLK);
      step_btn = 1'b0;
      repeat (8) @(negedge CLK);
    end
    @(negedge CLK);
    monOn = 1'b0;
    @(negedge CLK);
    check("press_pulses", 32'(pulses), 32'd10);
    check("press_rises", 32'(rises), 32'd10);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
